cc_matrix_scanner: RTL
======================

# cc_matrix_scanner

Scan controller that sequences the joined 8×8 playfield (car row merged over the environment rows) onto a multiplexed LED matrix. It snapshots all eight row buses into a shadow frame on a frame request, then drives one row at a time with a programmable dwell and inter-row blanking, wrapping continuously. At each snapshot it also checks the car row against environment row 0 and latches a sticky collision flag for the game FSM.

## Interface
- PRESCALE, 2500: clock cycles a row is driven (dwell), legal range 2..65535
- BLANK_CYCLES, 50: clock cycles all rows are off between rows, legal range 1..65535
- CC_MATRIX_SCANNER_CLOCK_50  in  1  system clock, single clock domain
- CC_MATRIX_SCANNER_RESET_InLow  in  1  reset, asynchronous assert, active-low
- enable_in  in  1  level; 1 = scan, 0 = display off
- frame_req_in  in  1  one-cycle pulse: new joined frame is valid on fila inputs
- fila7_in … fila0_in  in  8 each  joined row buses, row 7 = top
- car_fila0_in  in  8  car row (pre-join), for collision check
- env_fila0_in  in  8  environment row 0 (pre-join), for collision check
- collision_clr_in  in  1  pulse: clear sticky collision flag
- row_sel_out  out  8  row drive, active-low one-hot (bit r low = row r on)
- col_out  out  8  column data for the selected row, active-high
- frame_ack_out  out  1  one-cycle pulse: snapshot taken
- busy_out  out  1  1 in any state other than IDLE
- collision_out  out  1  sticky collision flag

## Operation
- States: IDLE, LOAD, SCAN, BLANK.
- IDLE: row_sel_out=8'hFF, col_out=0. enable_in=1 → LOAD.
- LOAD (exactly 1 cycle): shadow[r] ← fila r input for r=0..7; frame_ack_out=1; pending cleared; collision check; row index ← 0; → SCAN.
- SCAN: row_sel_out = ~(1<<row), col_out = shadow[row]; dwell counter runs PRESCALE cycles; on terminal count → BLANK.
- BLANK: row_sel_out=8'hFF, col_out=0 for BLANK_CYCLES cycles; then:
  - row<7: row ← row+1, → SCAN.
  - row==7 and pending=1: → LOAD.
  - row==7 and pending=0: row ← 0, → SCAN with unchanged shadow (wrap-around).
- pending: set by frame_req_in in any state other than LOAD; a frame_req_in coincident with LOAD is consumed by that LOAD (not re-pended). Multiple requests within a frame collapse into one.
- Frames are only swapped at the row-7→row-0 boundary; a displayed frame is never torn.
- Collision: in LOAD, if (car_fila0_in & env_fila0_in) != 0, collision_out ← 1. collision_clr_in clears it; simultaneous set and clear → set wins. Flag is unaffected by enable_in.
- enable_in=0 in any state → IDLE next cycle; pending cleared; shadow retained; counters reset.

## Timing
- Reset values: row_sel_out=8'hFF, col_out=8'h00, frame_ack_out=0, busy_out=0, collision_out=0; state IDLE, row=0, pending=0, shadow all zero.
- All outputs registered. enable_in sampled high in cycle t → LOAD in t+1 (frame_ack_out high in t+1) → row 0 driven from t+2.
- Row r on for exactly PRESCALE cycles, off for exactly BLANK_CYCLES cycles.
- Steady frame period = 8·(PRESCALE+BLANK_CYCLES) cycles, +1 when a LOAD is inserted.
- Request-to-display latency: at most one full frame period +1 cycle.
- Reset assertion mid-scan: outputs go to reset values asynchronously, without waiting for a clock edge.

## Structure
- Shared package cc_matrix_pkg: state enum (IDLE, LOAD, SCAN, BLANK), ROWS=8, ROW_OFF=8'hFF, row-width and counter-width constants.
- One sub-module: cc_dwell_counter (loadable down-counter with terminal-count pulse, 16-bit), used for both SCAN dwell and BLANK durations.
- Shadow frame is 8×8 flops local to the scanner.

## Test plan
- Reset then enable_in=1 with PRESCALE=4, BLANK_CYCLES=2, fila0=8'hA5 → frame_ack pulse 1 cycle after enable; row_sel=8'hFE, col=8'hA5 for 4 cycles; then 8'hFF/8'h00 for 2 cycles.
- Full frame, rows loaded 8'h01..8'h80 → row_sel steps FE,FD,…,7F in order; frame period 48 cycles; wraps to row 0 with the same data when no request arrives.
- frame_req mid-row 3 with new data → old frame finishes through row 7; LOAD then new data from row 0; two requests in one frame → exactly one frame_ack.
- car_fila0=8'h18, env_fila0=8'h10 at LOAD → collision_out=1 and stays 1; collision_clr in same cycle as a new collision LOAD → stays 1; later clr alone → 0.
- enable_in dropped during SCAN of row 5 → next cycle row_sel=8'hFF, busy=0; re-enable → LOAD, scan restarts at row 0.
- Async reset asserted during BLANK → all outputs at reset values before the next clock edge; collision_out cleared.

Source files
------------

// File: rtl/cc_matrix_pkg.sv
// cc_matrix_pkg: shared types and sizes for the LED matrix scanner
package cc_matrix_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SCAN, BLANK} state_t;
  localparam int ROWS = 8;
  localparam int ROW_W = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;
  localparam logic [ROW_W-1:0] ROW_OFF = 8'hFF;
  function automatic logic [ROW_W-1:0] row_drive(input logic [IDX_W-1:0] r);
    return ~(ROW_W'(1) << r);
  endfunction
endpackage

// File: rtl/cc_matrix_scanner_if.sv
// cc_matrix_scanner_if: frame/collision inputs and matrix drive outputs of the scanner
interface cc_matrix_scanner_if;
  import cc_matrix_pkg::*;
  logic enable_in, frame_req_in, collision_clr_in;
  logic [ROW_W-1:0] fila0_in, fila1_in, fila2_in, fila3_in, fila4_in, fila5_in, fila6_in, fila7_in;
  logic [ROW_W-1:0] car_fila0_in, env_fila0_in;
  logic [ROW_W-1:0] row_sel_out, col_out;
  logic frame_ack_out, busy_out, collision_out;
  modport master(
    output enable_in, frame_req_in, collision_clr_in, fila0_in, fila1_in, fila2_in, fila3_in,
           fila4_in, fila5_in, fila6_in, fila7_in, car_fila0_in, env_fila0_in,
    input row_sel_out, col_out, frame_ack_out, busy_out, collision_out
  );
  modport slave(
    input enable_in, frame_req_in, collision_clr_in, fila0_in, fila1_in, fila2_in, fila3_in,
          fila4_in, fila5_in, fila6_in, fila7_in, car_fila0_in, env_fila0_in,
    output row_sel_out, col_out, frame_ack_out, busy_out, collision_out
  );
endinterface

// File: rtl/cc_dwell_counter.sv
// cc_dwell_counter: loadable down-counter, tc high while the count sits at zero
module cc_dwell_counter
  import cc_matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  assign tc = cnt == '0;
endmodule

// File: rtl/cc_matrix_scanner.sv
// cc_matrix_scanner: snapshots the joined 8x8 playfield and multiplexes it row by row onto an LED matrix
module cc_matrix_scanner
  import cc_matrix_pkg::*;
#(
  parameter int PRESCALE = 2500,
  parameter int BLANK_CYCLES = 50
) (
  input logic CC_MATRIX_SCANNER_CLOCK_50,
  input logic CC_MATRIX_SCANNER_RESET_InLow,
  cc_matrix_scanner_if.slave bus
);
  state_t st, st_nxt;
  logic [IDX_W-1:0] row, row_nxt;
  logic pending, pending_nxt, tc, load;
  logic [CNT_W-1:0] load_val;
  logic [ROW_W-1:0] fila [ROWS];
  logic [ROW_W-1:0] shadow [ROWS];
  logic [ROW_W-1:0] shadow_nxt [ROWS];
  logic [ROW_W-1:0] row_sel_nxt, col_nxt;
  logic ack_nxt, busy_nxt, coll_nxt;

  assign fila = '{bus.fila0_in, bus.fila1_in, bus.fila2_in, bus.fila3_in,
                  bus.fila4_in, bus.fila5_in, bus.fila6_in, bus.fila7_in};

  cc_dwell_counter u_dwell (
    .clk(CC_MATRIX_SCANNER_CLOCK_50),
    .rst_n(CC_MATRIX_SCANNER_RESET_InLow),
    .load(load),
    .load_val(load_val),
    .tc(tc)
  );

  always_ff @(posedge CC_MATRIX_SCANNER_CLOCK_50 or negedge CC_MATRIX_SCANNER_RESET_InLow)
    if (!CC_MATRIX_SCANNER_RESET_InLow) begin
      st <= IDLE;
      row <= '0;
      pending <= 1'b0;
      shadow <= '{default: '0};
      bus.row_sel_out <= ROW_OFF;
      bus.col_out <= '0;
      bus.frame_ack_out <= 1'b0;
      bus.busy_out <= 1'b0;
      bus.collision_out <= 1'b0;
    end else begin
      st <= st_nxt;
      row <= row_nxt;
      pending <= pending_nxt;
      shadow <= shadow_nxt;
      bus.row_sel_out <= row_sel_nxt;
      bus.col_out <= col_nxt;
      bus.frame_ack_out <= ack_nxt;
      bus.busy_out <= busy_nxt;
      bus.collision_out <= coll_nxt;
    end

  // A new frame is only taken after row 7's blanking, so a displayed frame never tears
  always_comb begin
    st_nxt = !bus.enable_in ? IDLE :
             st == IDLE ? LOAD :
             st == LOAD ? SCAN :
             !tc ? st :
             st == SCAN ? BLANK :
             (&row && pending) ? LOAD : SCAN;
    row_nxt = (!bus.enable_in || st == LOAD) ? '0 : (st == BLANK && tc) ? row + IDX_W'(1) : row;
    pending_nxt = bus.enable_in && st != LOAD && (pending || bus.frame_req_in);
    load = st_nxt != st;
    load_val = st_nxt == SCAN ? CNT_W'(PRESCALE - 1) :
               st_nxt == BLANK ? CNT_W'(BLANK_CYCLES - 1) : '0;
  end

  // Outputs are registered from next-state values so they line up with the state they describe
  always_comb begin
    foreach (shadow_nxt[r]) shadow_nxt[r] = st == LOAD ? fila[r] : shadow[r];
    row_sel_nxt = st_nxt == SCAN ? row_drive(row_nxt) : ROW_OFF;
    col_nxt = st_nxt == SCAN ? shadow_nxt[row_nxt] : '0;
    ack_nxt = st_nxt == LOAD;
    busy_nxt = st_nxt != IDLE;
    coll_nxt = (st == LOAD && |(bus.car_fila0_in & bus.env_fila0_in)) ||
               (bus.collision_out && !bus.collision_clr_in);
  end
endmodule
